led_sequencer: RTL
==================

LED_SEQUENCER -- requirements
Module: led_sequencer

Interface
REQ-001 Parameter N_LEDS, default 4: LED count and pattern width; legal values are 2 or more.
REQ-002 Parameter DIV_W, default 25: prescaler counter and div width; legal values are 1 or more.
REQ-003 Parameter PWM_W, default 4: PWM counter and brightness width; used only with the PWM macro.
REQ-004 Port clk, input, 1: clock.
REQ-005 Port rst, input, 1: reset rst, synchronous, active-high.
REQ-006 Port en, input, 1: free-run enable for the prescaler.
REQ-007 Port mode, input, 2: 00 rotate right, 01 rotate left, 10 bounce, 11 binary count.
REQ-008 Port div, input, DIV_W: step period is div+1 clk cycles.
REQ-009 Port step_req, input, 1: single-step pulse, honoured only while en=0.
REQ-010 Port brightness, input, PWM_W: duty setting; present only with the PWM macro.
REQ-011 Port leds, output, N_LEDS: displayed pattern.
REQ-012 Port tick, output, 1: one-cycle pulse coincident with each new pattern.

Function
REQ-013 The prescaler counter cnt SHALL increment on every cycle with en=1 and hold while en=0.
REQ-014 A step SHALL occur when (en=1 and cnt>=div) or (en=0 and step_req=1); on an en-driven step, cnt returns to 0 at the same edge.
REQ-015 div=0 SHALL produce a step on every cycle; if div drops below cnt, cnt>=div triggers a step on the next cycle, with no long wrap.
REQ-016 On a step, the pattern register SHALL update at that clock edge; tick SHALL be registered high for exactly the following cycle.
REQ-017 step_req while en=1 SHALL be ignored; a held step_req while en=0 steps on every cycle.
REQ-018 Rotate right SHALL produce {p[0],p[N-1:1]}; rotate left SHALL produce {p[N-2:0],p[N-1]}.
REQ-019 Bounce SHALL hold an internal direction bit. Going left with p[N-1]=1, direction flips to right and the pattern shifts right in the same step. Going right with p[0]=1, direction flips to left and the pattern shifts left. Otherwise the pattern shifts in the current direction, zero-filled.
REQ-020 Binary count SHALL produce p+1 modulo 2^N_LEDS.
REQ-021 In rotate or bounce modes, a step with pattern==0 SHALL load 1 instead.
REQ-022 A mode change SHALL take effect on the next step; the pattern and the bounce direction are retained.
REQ-023 Without PWM, leds SHALL equal the pattern register directly, with no added latency.

Reset
REQ-024 rst SHALL set pattern=1, cnt=0, bounce direction=left, and tick=0; without PWM, leds=1 in the cycle after the reset edge.
REQ-025 rst asserted mid-sequence SHALL override en, step_req, and any step in the same cycle.
REQ-026 With PWM, rst SHALL also clear pwm_cnt to 0.

Configuration
REQ-027 With macro LED_SEQUENCER_PWM_EN defined, the brightness port SHALL exist, and a free-running PWM_W-bit pwm_cnt SHALL count every cycle.
REQ-028 With the macro defined, leds SHALL equal pattern when pwm_cnt<brightness and SHALL be all zeros otherwise.
REQ-029 brightness=0 SHALL give leds permanently 0; the maximum brightness gives a duty of (2^PWM_W-1)/2^PWM_W.
REQ-030 With the macro undefined, the brightness port and pwm_cnt SHALL be absent, and leds SHALL equal the pattern.

Structure
REQ-031 Package led_sequencer_pkg SHALL hold the mode encoding constants (MODE_ROR, MODE_ROL, MODE_BOUNCE, MODE_COUNT) and the bounce direction constants.
REQ-032 Prescaler logic (cnt, the compare, the en/step_req step generation) SHALL be a sub-module led_prescaler, parameterised by DIV_W, with a single step output.

Verification
REQ-033 Scenario: N=4, mode=00, div=3, en=1 after reset -> leds 0001,1000,0100,0010,0001, each held 4 cycles, with tick on each change.
REQ-034 Scenario: mode=01, div=0 -> 0001,0010,0100,1000,0001 on consecutive cycles.
REQ-035 Scenario: mode=10, div=0 -> 0001,0010,0100,1000,0100,0010,0001,0010.
REQ-036 Scenario: mode=11, div=0, run to 1111 -> next 0000; then mode=00 -> next 0001; tick on every step.
REQ-037 Scenario: en=0 with three isolated step_req pulses in mode 01 -> exactly three advances and three ticks. Then en=1, div=10 until cnt=7, then div=2 -> step on the next cycle. rst asserted mid-run -> 0001 and cnt=0.
REQ-038 Scenario (PWM): PWM_W=4, brightness=4 -> leds equal the pattern for 4 of every 16 cycles; brightness=0 -> leds always 0000.

Source files
------------

// File: rtl/led_sequencer_pkg.sv
// rtl/led_sequencer_pkg.sv - mode encodings and bounce direction type for led_sequencer
package led_sequencer_pkg;

  localparam logic [1:0] MODE_ROR    = 2'b00;
  localparam logic [1:0] MODE_ROL    = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic [1:0] MODE_COUNT  = 2'b11;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

endpackage

// File: rtl/led_prescaler.sv
// rtl/led_prescaler.sv - free-run divider with single-step override, one step strobe out
module led_prescaler #(
  parameter int DIV_W = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  input  logic             step_req,
  output logic             step
);

  localparam logic [DIV_W-1:0] CNT_ONE = 1;

  logic [DIV_W-1:0] cnt;

  // Compare with >= so a div lowered below cnt steps at once instead of wrapping.
  assign step = en ? (cnt >= div) : step_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt >= div) cnt <= '0;
      else            cnt <= cnt + CNT_ONE;
    end
  end

endmodule

// File: rtl/led_sequencer.sv
// rtl/led_sequencer.sv - LED pattern sequencer (rotate/bounce/count); LED_SEQUENCER_PWM_EN adds brightness PWM
module led_sequencer
  import led_sequencer_pkg::*;
#(
  parameter int N_LEDS = 4,
  parameter int DIV_W  = 25,
  parameter int PWM_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic [DIV_W-1:0]  div,
  input  logic              step_req,
`ifdef LED_SEQUENCER_PWM_EN
  input  logic [PWM_W-1:0]  brightness,
`endif
  output logic [N_LEDS-1:0] leds,
  output logic              tick
);

  localparam logic [N_LEDS-1:0] PAT_ONE = 1;

  logic              step;
  logic [N_LEDS-1:0] pattern, pattern_next;
  dir_t              dir, dir_next;

  led_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .div      (div),
    .step_req (step_req),
    .step     (step)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pattern <= PAT_ONE;
      dir     <= DIR_LEFT;
      tick    <= 1'b0;
    end else begin
      pattern <= pattern_next;
      dir     <= dir_next;
      tick    <= step;
    end
  end

  always_comb begin
    pattern_next = pattern;
    dir_next     = dir;
    if (step) begin
      // An all-zero pattern would freeze the shifting modes, so reseed it.
      if (mode != MODE_COUNT && pattern == '0) begin
        pattern_next = PAT_ONE;
      end else begin
        case (mode)
          MODE_ROR: pattern_next = {pattern[0], pattern[N_LEDS-1:1]};
          MODE_ROL: pattern_next = {pattern[N_LEDS-2:0], pattern[N_LEDS-1]};
          MODE_BOUNCE: begin
            if (dir == DIR_LEFT) begin
              if (pattern[N_LEDS-1]) begin
                dir_next     = DIR_RIGHT;
                pattern_next = pattern >> 1;
              end else begin
                pattern_next = pattern << 1;
              end
            end else begin
              if (pattern[0]) begin
                dir_next     = DIR_LEFT;
                pattern_next = pattern << 1;
              end else begin
                pattern_next = pattern >> 1;
              end
            end
          end
          default: pattern_next = pattern + PAT_ONE;
        endcase
      end
    end
  end

`ifdef LED_SEQUENCER_PWM_EN
  localparam logic [PWM_W-1:0] PWM_ONE = 1;

  logic [PWM_W-1:0] pwm_cnt;

  always_ff @(posedge clk) begin
    if (rst) pwm_cnt <= '0;
    else     pwm_cnt <= pwm_cnt + PWM_ONE;
  end

  assign leds = (pwm_cnt < brightness) ? pattern : '0;
`else
  assign leds = pattern;
`endif

endmodule
